cog_vid_lite: RTL and testbench

- Video shift unit for one cog, directly downstream of the cog counter.
- Consumes the counter's PLL output, delivered as a one-cycle pll_tick strobe already synchronised to clk_cog.
- Serialises WAITVID colour/pixel longs into an 8-bit colour stream on a selected pin group.
- Its pin_out is OR-ed with the counter's pin_out at the cog pin mux.

---
 rtl/cog_vid_pkg.sv | 32 +++
 rtl/cog_vid_pixsel.sv | 22 ++
 rtl/cog_vid_lite.sv | 163 ++++++++++++++++
 tb/tb_cog_vid_lite.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cog_vid_pkg.sv
// Shared definitions for the cog video shift unit: register field positions,
// FSM states, pixel modes and the pixel-register shift helper.
package cog_vid_pkg;

  localparam int VCFG_EN_HI    = 30;
  localparam int VCFG_EN_LO    = 29;
  localparam int VCFG_MODE_BIT = 28;
  localparam int VCFG_GRP_HI   = 10;
  localparam int VCFG_GRP_LO   = 9;
  localparam int VCFG_MASK_HI  = 7;
  localparam int VCFG_MASK_LO  = 0;
  localparam int VSCL_PC_LO    = 12;

  localparam int PIX_PER_FRAME_2BPP = 16;
  localparam int PIX_PER_FRAME_1BPP = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  typedef enum logic {
    MODE_2BPP = 1'b0,
    MODE_1BPP = 1'b1
  } mode_t;

  function automatic logic [31:0] shift_pixels(input logic [31:0] pix, input mode_t mode);
    return (mode == MODE_1BPP) ? (pix >> 1) : (pix >> 2);
  endfunction

endpackage

// File: rtl/cog_vid_pixsel.sv
// Combinational colour lookup: pixel index -> colour byte, masked and placed
// on the selected 8-bit pin group.
module cog_vid_pixsel
  import cog_vid_pkg::*;
(
  input  logic [1:0]  idx,
  input  mode_t       mode,
  input  logic [31:0] colors,
  input  logic [7:0]  mask,
  input  logic [1:0]  group,
  output logic [31:0] pin_word
);

  logic [1:0] sel;
  logic [7:0] byte_val;

  // 1bpp only ever reaches colour bytes 0 and 1.
  assign sel      = (mode == MODE_1BPP) ? {1'b0, idx[0]} : idx;
  assign byte_val = colors[{sel, 3'b000} +: 8] & mask;
  assign pin_word = {24'h0, byte_val} << {group, 3'b000};

endmodule

// File: rtl/cog_vid_lite.sv
// Cog video shift unit: buffers WAITVID longs and serialises them onto a pin
// group on each pll_tick. Optional macro COG_VID_UNDERRUN_EN adds underrun_cnt.
module cog_vid_lite
  import cog_vid_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int FRM_W = 12
) (
  input  logic        clk_cog,
  input  logic        rst,
  input  logic        ena,
  input  logic        setvcfg,
  input  logic        setvscl,
  input  logic [31:0] data,
  input  logic        pll_tick,
  input  logic        waitvid,
  input  logic [31:0] colors,
  input  logic [31:0] pixels,
  output logic        ack,
  output logic [31:0] pin_out,
  output logic        busy
`ifdef COG_VID_UNDERRUN_EN
  ,
  output logic [7:0]  underrun_cnt
`endif
);

  logic [1:0]       en_q;
  mode_t            mode_q;
  logic [1:0]       grp_q;
  logic [7:0]       mask_q;
  logic [PIX_W-1:0] pc_q, pcnt;
  logic [FRM_W-1:0] fc_q, fcnt;

  logic        buf_full;
  logic [31:0] buf_colors, buf_pixels;
  logic [31:0] colors_q, pix_save, pix_sh;

  state_t      state, state_n;
  logic        do_load, do_run, disable_wr, pix_last;
  logic [31:0] ld_colors, ld_pixels, pix_next, sel_colors, pin_word;

  logic unused_data;
  assign unused_data = ^data;

  assign disable_wr = setvcfg && (data[VCFG_EN_HI:VCFG_EN_LO] == 2'b00);
  assign pix_last   = (pcnt == PIX_W'(1));
  assign busy       = (state != IDLE);
  assign ack        = waitvid && !buf_full && ena && !rst;

  // An empty buffer at LOAD replays the previous frame's longs.
  assign ld_colors = buf_full ? buf_colors : colors_q;
  assign ld_pixels = buf_full ? buf_pixels : pix_save;

  always_ff @(posedge clk_cog or posedge rst) begin
    if (rst)       state <= IDLE;
    else if (!ena) state <= IDLE;
    else           state <= state_n;
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_n = state;
    do_load = 1'b0;
    do_run  = 1'b0;
    case (state)
      IDLE: if (pll_tick && (en_q != 2'b00)) state_n = LOAD;
      LOAD: if (pll_tick) begin
        do_load = 1'b1;
        state_n = RUN;
      end
      RUN:  if (pll_tick) begin
        if (fcnt == FRM_W'(1)) do_load = 1'b1;
        else                   do_run  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (disable_wr) begin
      state_n = IDLE;
      do_load = 1'b0;
      do_run  = 1'b0;
    end
  end

  always_comb begin
    pix_next   = pix_sh;
    sel_colors = colors_q;
    if (do_load) begin
      pix_next   = ld_pixels;
      sel_colors = ld_colors;
    end else if (pix_last) begin
      pix_next = shift_pixels(pix_sh, mode_q);
    end
  end

  cog_vid_pixsel u_pixsel (
    .idx      (pix_next[1:0]),
    .mode     (mode_q),
    .colors   (sel_colors),
    .mask     (mask_q),
    .group    (grp_q),
    .pin_word (pin_word)
  );

  always_ff @(posedge clk_cog or posedge rst) begin
    if (rst) begin
      en_q <= '0; mode_q <= MODE_2BPP; grp_q <= '0; mask_q <= '0;
      pc_q <= '0; fc_q <= '0; pcnt <= '0; fcnt <= '0;
      buf_full <= 1'b0; buf_colors <= '0; buf_pixels <= '0;
      colors_q <= '0; pix_save <= '0; pix_sh <= '0; pin_out <= '0;
    end else if (!ena) begin
      en_q <= '0; mode_q <= MODE_2BPP; grp_q <= '0; mask_q <= '0;
      pc_q <= '0; fc_q <= '0; pcnt <= '0; fcnt <= '0;
      buf_full <= 1'b0; buf_colors <= '0; buf_pixels <= '0;
      colors_q <= '0; pix_save <= '0; pix_sh <= '0; pin_out <= '0;
    end else begin
      if (setvcfg) begin
        en_q   <= data[VCFG_EN_HI:VCFG_EN_LO];
        mode_q <= mode_t'(data[VCFG_MODE_BIT]);
        grp_q  <= data[VCFG_GRP_HI:VCFG_GRP_LO];
        mask_q <= data[VCFG_MASK_HI:VCFG_MASK_LO];
      end
      if (setvscl) begin
        pc_q <= data[VSCL_PC_LO +: PIX_W];
        fc_q <= data[FRM_W-1:0];
      end

      // ack implies the buffer was empty, so a same-cycle LOAD saw no data.
      if (ack) begin
        buf_colors <= colors;
        buf_pixels <= pixels;
        buf_full   <= 1'b1;
      end else if (do_load) begin
        buf_full <= 1'b0;
      end

      if (do_load) begin
        colors_q <= ld_colors;
        pix_save <= ld_pixels;
        pix_sh   <= pix_next;
        pcnt     <= pc_q;
        fcnt     <= fc_q;
      end else if (do_run) begin
        fcnt   <= fcnt - FRM_W'(1);
        pix_sh <= pix_next;
        pcnt   <= pix_last ? pc_q : (pcnt - PIX_W'(1));
      end

      if (disable_wr)             pin_out <= '0;
      else if (do_load || do_run) pin_out <= pin_word;
    end
  end

`ifdef COG_VID_UNDERRUN_EN
  always_ff @(posedge clk_cog or posedge rst) begin
    if (rst)                  underrun_cnt <= '0;
    else if (!ena || setvcfg) underrun_cnt <= '0;
    else if (do_load && (state == RUN) && !buf_full && (underrun_cnt != 8'hFF))
      underrun_cnt <= underrun_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_cog_vid_lite.sv
// Self-checking bench for cog_vid_lite: expected pin_out per pll_tick is queued
// at stimulus time and compared by a monitor one step after the clock edge.
module tb_cog_vid_lite;

  logic        clk_cog;
  logic        rst;
  logic        ena;
  logic        setvcfg;
  logic        setvscl;
  logic [31:0] data;
  logic        pll_tick;
  logic        waitvid;
  logic [31:0] colors;
  logic [31:0] pixels;
  logic        ack;
  logic [31:0] pin_out;
  logic        busy;
`ifdef COG_VID_UNDERRUN_EN
  logic [7:0]  underrun_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  cog_vid_lite dut (
    .clk_cog  (clk_cog),
    .rst      (rst),
    .ena      (ena),
    .setvcfg  (setvcfg),
    .setvscl  (setvscl),
    .data     (data),
    .pll_tick (pll_tick),
    .waitvid  (waitvid),
    .colors   (colors),
    .pixels   (pixels),
    .ack      (ack),
    .pin_out  (pin_out),
    .busy     (busy)
`ifdef COG_VID_UNDERRUN_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  initial clk_cog = 1'b0;
  always #5 clk_cog = ~clk_cog;

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Scoreboard: one queued expectation per pll_tick, compared after the edge.
  always @(posedge clk_cog) begin
    if (pll_tick === 1'b1 && rst === 1'b0) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty got=%h", pin_out);
      end else begin
        exp_w = exp_q.pop_front();
        if (pin_out !== exp_w) begin
          errors++;
          $display("FAIL pin_out_tick got=%h exp=%h t=%0t", pin_out, exp_w, $time);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_cog);
    #1;
  endtask

  task automatic tick(input logic [31:0] exp_pin);
    exp_q.push_back(exp_pin);
    pll_tick = 1'b1;
    step();
    pll_tick = 1'b0;
  endtask

  task automatic write_vcfg(input logic [31:0] d);
    setvcfg = 1'b1;
    data    = d;
    step();
    setvcfg = 1'b0;
    data    = '0;
  endtask

  task automatic write_vscl(input logic [31:0] d);
    setvscl = 1'b1;
    data    = d;
    step();
    setvscl = 1'b0;
    data    = '0;
  endtask

  task automatic load_buffer(input logic [31:0] c, input logic [31:0] p);
    bit got;
    got     = 1'b0;
    colors  = c;
    pixels  = p;
    waitvid = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      #1;
      if (ack === 1'b1) got = 1'b1;
      @(posedge clk_cog);
      #1;
    end
    waitvid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL load_buffer_ack got=0 exp=1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; setvcfg = 1'b0; setvscl = 1'b0; data = '0;
    pll_tick = 1'b0; waitvid = 1'b1; colors = 32'hFFFF_FFFF; pixels = 32'hFFFF_FFFF;
    step(); step();
    checks++; if (ack !== 1'b0)      begin errors++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++; if (pin_out !== 32'h0) begin errors++; $display("FAIL reset_pin_out got=%h exp=0", pin_out); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0; waitvid = 1'b0;
    step();
  endtask

  task automatic test_1bpp();
    write_vscl(32'h0000_1020);
    write_vcfg(32'h3000_02FF);
    load_buffer(32'h0000_AA55, 32'h0000_0001);
    tick(32'h0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got=%b exp=1", busy); end
    tick(32'h0000_AA00);
    for (int i = 1; i < 32; i++) begin
      tick(32'h0000_5500);
      if (i == 10) begin
        repeat (3) step();
        checks++;
        if (pin_out !== 32'h0000_5500) begin
          errors++; $display("FAIL hold_without_tick got=%h exp=00005500", pin_out);
        end
      end
    end
  endtask

  task automatic test_underrun();
    for (int f = 0; f < 2; f++) begin
      tick(32'h0000_AA00);
      for (int i = 1; i < 32; i++) tick(32'h0000_5500);
    end
    tick(32'h0000_AA00);
`ifdef COG_VID_UNDERRUN_EN
    checks++; if (underrun_cnt !== 8'd3) begin errors++; $display("FAIL underrun_cnt got=%0d exp=3", underrun_cnt); end
`endif
    write_vcfg(32'h0);
    checks++; if (pin_out !== 32'h0) begin errors++; $display("FAIL disable_pin_out got=%h exp=0", pin_out); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL disable_busy got=%b exp=0", busy); end
`ifdef COG_VID_UNDERRUN_EN
    checks++; if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL underrun_clear got=%0d exp=0", underrun_cnt); end
`endif
  endtask

  task automatic test_2bpp();
    write_vscl(32'h0000_4010);
    write_vcfg(32'h2000_000F);
    load_buffer(32'h4433_2211, 32'h0000_00E4);
    tick(32'h0);
    tick(32'h0000_0001);
    load_buffer(32'h4433_2211, 32'h0000_001B);
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < 4; r++)
        if (p != 0 || r != 0) tick(32'(p + 1));
  endtask

  task automatic test_handshake();
    colors  = 32'h0D0C_0B0A;
    pixels  = 32'h0;
    waitvid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL stall_ack got=%b exp=0", ack); end
      @(posedge clk_cog);
      #1;
    end
    exp_q.push_back(32'h0000_0004);
    pll_tick = 1'b1;
    #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL load_cycle_ack got=%b exp=0", ack); end
    @(posedge clk_cog);
    #1;
    pll_tick = 1'b0;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ack_after_load got=%b exp=1", ack); end
    step();
    colors = 32'h0403_0201;
    pixels = 32'h0000_00E4;
    #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL second_request_ack got=%b exp=0", ack); end
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < 4; r++)
        if (p != 0 || r != 0) begin
          tick(32'(4 - p));
          checks++; if (ack !== 1'b0) begin errors++; $display("FAIL frame_stall_ack got=%b exp=0", ack); end
        end
    tick(32'h0000_000A);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ack_next_frame got=%b exp=1", ack); end
    step();
    waitvid = 1'b0;
  endtask

  task automatic test_zero_encoding();
    logic [31:0] e;
    int          k;
    write_vcfg(32'h0);
    write_vscl(32'h0);
    write_vcfg(32'h2000_06FF);
    tick(32'h0);
    tick(32'h0100_0000);
    load_buffer(32'h0000_00AA, 32'h0);
    for (int t = 2; t <= 4096; t++) begin
      k = (t - 1) / 256;
      e = (k < 4) ? (32'(k + 1) << 24) : 32'h0100_0000;
      tick(e);
    end
    tick(32'hAA00_0000);
  endtask

  task automatic test_reset_midrun();
    waitvid = 1'b1;
    colors  = 32'h1234_5678;
    rst     = 1'b1;
    #1;
    checks++; if (ack !== 1'b0)      begin errors++; $display("FAIL midrun_ack got=%b exp=0", ack); end
    checks++; if (pin_out !== 32'h0) begin errors++; $display("FAIL midrun_pin_out got=%h exp=0", pin_out); end
    step();
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midrun_busy got=%b exp=0", busy); end
    rst     = 1'b0;
    waitvid = 1'b0;
    step();
    repeat (4) tick(32'h0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset got=%b exp=0", busy); end
    write_vcfg(32'h3000_02FF);
    tick(32'h0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_after_setvcfg got=%b exp=1", busy); end
    write_vcfg(32'h0);
  endtask

  task automatic test_ena();
    write_vscl(32'h0000_1020);
    write_vcfg(32'h3000_02FF);
    load_buffer(32'h0000_AA55, 32'h0000_0001);
    tick(32'h0);
    tick(32'h0000_AA00);
    tick(32'h0000_5500);
    ena     = 1'b0;
    waitvid = 1'b1;
    #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ena_low_ack got=%b exp=0", ack); end
    step();
    checks++; if (pin_out !== 32'h0) begin errors++; $display("FAIL ena_low_pin_out got=%h exp=0", pin_out); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL ena_low_busy got=%b exp=0", busy); end
    ena     = 1'b1;
    waitvid = 1'b0;
    repeat (3) tick(32'h0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ena_cleared_cfg got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_1bpp();
    test_underrun();
    test_2bpp();
    test_handshake();
    test_zero_encoding();
    test_reset_midrun();
    test_ena();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
